// File: rtl/ramd64_pkg.sv
// Shared constants, pointer type and parity helper for the 64-deep LUT-RAM stream reader.
package ramd64_pkg;

    localparam int RAMD64_DEPTH = 64;
    localparam int RAMD64_AW    = 6;
    localparam int RAMD64_PW    = 7;

    typedef logic [RAMD64_PW-1:0] ptr_t;

    // Even parity bit: XOR of all data bits, so data plus parity has an even number of ones.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ramd64_stream_mem.sv
// 64-entry distributed RAM: synchronous write, asynchronous read, no reset on contents.
module ramd64_stream_mem
    import ramd64_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_wr_en,
    input  logic [RAMD64_AW-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]     i_wr_data,
    input  logic [RAMD64_AW-1:0] i_rd_addr,
    output logic [WIDTH-1:0]     o_rd_data
);

    logic [WIDTH-1:0] r_mem [RAMD64_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ramd64_stream_reader.sv
// FIFO-order drain of a 64-deep LUT RAM onto a valid/ready stream with a registered FWFT output.
// Optional stored even parity with a PERR pulse: define RAMD64_STREAM_READER_PARITY_EN.
module ramd64_stream_reader
    import ramd64_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] WR_DATA,
    output logic             FULL,
    output logic             RD_VALID,
    input  logic             RD_READY,
    output logic [WIDTH-1:0] RD_DATA,
`ifdef RAMD64_STREAM_READER_PARITY_EN
    output logic             PERR,
`endif
    output logic [6:0]       COUNT
);

    if (DEPTH_LOG2 != RAMD64_AW) begin : g_bad_depth
        $error("ramd64_stream_reader: DEPTH_LOG2 must be 6");
    end

`ifdef RAMD64_STREAM_READER_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif

    ptr_t             r_wptr;
    ptr_t             r_rptr;
    logic             r_rd_valid;
    logic [WIDTH-1:0] r_rd_data;
    logic [MW-1:0]    w_wr_word;
    logic [MW-1:0]    w_rd_word;
    logic             w_ram_empty;
    logic             w_full;
    logic             w_wr;
    logic             w_load;
    ptr_t             w_ram_cnt;

    assign w_ram_empty = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[RAMD64_AW-1:0] == r_rptr[RAMD64_AW-1:0]) &&
                         (r_wptr[RAMD64_AW] != r_rptr[RAMD64_AW]);
    // A pop in the same cycle never frees a slot for a write: FULL is evaluated pre-edge.
    assign w_wr        = WR_EN && !w_full;
    assign w_load      = !w_ram_empty && (!r_rd_valid || RD_READY);
    assign w_ram_cnt   = r_wptr - r_rptr;

`ifdef RAMD64_STREAM_READER_PARITY_EN
    assign w_wr_word = {even_parity(64'(WR_DATA)), WR_DATA};
`else
    assign w_wr_word = WR_DATA;
`endif

    ramd64_stream_mem #(.WIDTH(MW)) u_mem (
        .i_clk     (CLK),
        .i_wr_en   (w_wr),
        .i_wr_addr (r_wptr[RAMD64_AW-1:0]),
        .i_wr_data (w_wr_word),
        .i_rd_addr (r_rptr[RAMD64_AW-1:0]),
        .o_rd_data (w_rd_word)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_load) begin
                r_rptr     <= r_rptr + 1'b1;
                r_rd_data  <= w_rd_word[WIDTH-1:0];
                r_rd_valid <= 1'b1;
            end else if (r_rd_valid && RD_READY) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

`ifdef RAMD64_STREAM_READER_PARITY_EN
    logic r_perr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_load && (even_parity(64'(w_rd_word[WIDTH-1:0])) != w_rd_word[WIDTH]);
        end
    end

    assign PERR = r_perr;
`endif

    assign FULL     = w_full;
    assign RD_VALID = r_rd_valid;
    assign RD_DATA  = r_rd_data;
    assign COUNT    = w_ram_cnt + {6'd0, r_rd_valid};

endmodule

// File: tb/tb_ramd64_stream_reader.sv
// Self-checking bench for ramd64_stream_reader against a queue-based stream model.
module tb_ramd64_stream_reader;

    localparam int W = 8;

    logic         CLK;
    logic         RST_N;
    logic         WR_EN;
    logic [W-1:0] WR_DATA;
    logic         FULL;
    logic         RD_VALID;
    logic         RD_READY;
    logic [W-1:0] RD_DATA;
    logic [6:0]   COUNT;
`ifdef RAMD64_STREAM_READER_PARITY_EN
    logic         PERR;
`endif

    ramd64_stream_reader #(.WIDTH(W), .DEPTH_LOG2(6)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .WR_EN    (WR_EN),
        .WR_DATA  (WR_DATA),
        .FULL     (FULL),
        .RD_VALID (RD_VALID),
        .RD_READY (RD_READY),
        .RD_DATA  (RD_DATA),
`ifdef RAMD64_STREAM_READER_PARITY_EN
        .PERR     (PERR),
`endif
        .COUNT    (COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Model: words held in RAM, plus the output register.
    logic [W-1:0] q_ram[$];
    logic [W-1:0] pops[$];
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    logic         m_perr  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_ram.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_perr  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(RD_VALID), 32'(m_valid));
        chk({tag, ".data"},  32'(RD_DATA),  32'(m_data));
        chk({tag, ".full"},  32'(FULL),     32'(q_ram.size() == 64));
        chk({tag, ".count"}, 32'(COUNT),    32'(q_ram.size()) + 32'(m_valid));
`ifdef RAMD64_STREAM_READER_PARITY_EN
        chk({tag, ".perr"},  32'(PERR),     32'(m_perr));
`endif
    endtask

    task automatic step(input string tag, input logic wr, input logic [W-1:0] d, input logic rdy);
        bit m_full;
        bit m_load;
        WR_EN    = wr;
        WR_DATA  = d;
        RD_READY = rdy;
        m_full = (q_ram.size() == 64);
        m_load = (q_ram.size() != 0) && (!m_valid || rdy);
        if (m_valid && rdy) pops.push_back(m_data);
        @(posedge CLK);
        if (m_load) begin
            m_data  = q_ram.pop_front();
            m_valid = 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (wr && !m_full) q_ram.push_back(d);
        #1;
        check_all(tag);
    endtask

    initial begin
        WR_EN    = 1'b0;
        WR_DATA  = '0;
        RD_READY = 1'b0;
        RST_N    = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) step("idle", 1'b0, '0, 1'b0);

        // Single word, held while the consumer stalls.
        step("wr_a5", 1'b1, 8'hA5, 1'b0);
        step("a5_out", 1'b0, '0, 1'b0);
        chk("a5_visible", 32'(RD_VALID && RD_DATA == 8'hA5), 32'd1);
        repeat (10) step("a5_hold", 1'b0, '0, 1'b0);
        step("a5_pop", 1'b0, '0, 1'b1);

        // Fill to FULL with 65 words, drop one, then drain in order.
        for (int i = 0; i < 65; i++) step("fill", 1'b1, W'(i), 1'b0);
        chk("fill_full", 32'(FULL), 32'd1);
        chk("fill_count", 32'(COUNT), 32'd65);
        step("drop_ff", 1'b1, 8'hFF, 1'b0);
        chk("drop_count", 32'(COUNT), 32'd65);
        pops.delete();
        for (int i = 0; i < 66; i++) step("drain", 1'b0, '0, 1'b1);
        chk("drain_n", 32'(pops.size()), 32'd65);
        for (int i = 0; i < pops.size(); i++) chk("drain_order", 32'(pops[i]), 32'(i));

        // Sustained streaming across pointer wrap.
        for (int i = 0; i < 300; i++) step("stream", 1'b1, W'($urandom), 1'b1);
        repeat (3) step("stream_tail", 1'b0, '0, 1'b1);

        // Random traffic, biased toward writes so FULL is visited.
        for (int i = 0; i < 600; i++)
            step("rand", ($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 2) == 0));
        for (int i = 0; i < 70; i++) step("rand_drain", 1'b0, '0, 1'b1);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 20; i++) step("pre_rst", 1'b1, W'($urandom), 1'b0);
        chk("pre_rst_count", 32'(COUNT), 32'd20);
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge CLK);
        RST_N = 1'b1;
        step("post_rst_wr", 1'b1, 8'h3C, 1'b0);
        step("post_rst_out", 1'b0, '0, 1'b0);
        chk("post_rst_first", 32'(RD_DATA), 32'h3C);
        step("post_rst_pop", 1'b0, '0, 1'b1);

`ifdef RAMD64_STREAM_READER_PARITY_EN
        begin
            logic [5:0] a;
            step("par_wr0e", 1'b1, 8'h0E, 1'b0);
            a = dut.r_wptr[5:0];
            step("par_wr0f", 1'b1, 8'h0F, 1'b0);
            step("par_wr10", 1'b1, 8'h10, 1'b0);
            dut.u_mem.r_mem[a][W] = ~dut.u_mem.r_mem[a][W];
            m_perr = 1'b1;
            step("par_bad", 1'b0, '0, 1'b1);
            m_perr = 1'b0;
            step("par_next", 1'b0, '0, 1'b1);
            step("par_end", 1'b0, '0, 1'b1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
